mem_ctrl: RTL and testbench

Memory-side responder for the core's `ram_read`/`ram_write` request protocol. It accepts one 16-bit word request per transaction from the decoder/datapath and runs it on an external asynchronous 8-bit SRAM as two byte accesses with programmable wait states. It returns `mem_busy`/`mem_ready` so the decoder can stall `pc_inc` and capture load data. It sits between the core datapath (ALU address output, register read port) and the board SRAM pins.

---
 rtl/mem_pkg.sv | 18 +
 rtl/sram_phase_timer.sv | 25 ++
 rtl/mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and widths for the word-to-byte SRAM controller
package mem_pkg;

    localparam int MEM_WORD_W  = 16;
    localparam int SRAM_BYTE_W = 8;
    localparam int SRAM_ADDR_W = 17;
    localparam int PHASE_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } mem_state_t;

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter timing one SRAM byte phase
import mem_pkg::*;

module sram_phase_timer (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [PHASE_CNT_W-1:0] load_val,
    output logic [PHASE_CNT_W-1:0] count,
    output logic                   last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - 16-bit request responder on an 8-bit async SRAM; MEM_CTRL_RDCACHE_EN adds a last-read cache
import mem_pkg::*;

module mem_ctrl #(
    parameter int WAIT_STATES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ram_read,
    input  logic                   ram_write,
    input  logic [MEM_WORD_W-1:0]  req_addr,
    input  logic [MEM_WORD_W-1:0]  req_wdata,
    output logic                   mem_busy,
    output logic                   mem_ready,
    output logic [MEM_WORD_W-1:0]  mem_rdata,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    input  logic [SRAM_BYTE_W-1:0] sram_dq_i,
    output logic [SRAM_BYTE_W-1:0] sram_dq_o,
    output logic                   sram_dq_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);

    localparam logic [PHASE_CNT_W-1:0] PHASE_LOAD = PHASE_CNT_W'(WAIT_STATES);

    mem_state_t             state;
    logic [MEM_WORD_W-1:0]  addr_q;
    logic [SRAM_BYTE_W-1:0] wdata_hi_q;
    logic [SRAM_BYTE_W-1:0] lo_byte;
    logic [PHASE_CNT_W-1:0] tmr_count;
    logic                   tmr_last;
    logic                   tmr_load;
    logic                   accept;
    logic                   rd_done;
    logic                   cache_hit;
    logic [MEM_WORD_W-1:0]  cache_rdata;

    assign accept  = (state == IDLE) || (state == DONE);
    assign rd_done = (state == RD_HI) && tmr_last;
    // Reload on a new transaction and on the low-to-high byte handover.
    assign tmr_load = (accept && (ram_write || (ram_read && !cache_hit))) ||
                      (((state == RD_LO) || (state == WR_LO)) && tmr_last);

    sram_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (PHASE_LOAD),
        .count    (tmr_count),
        .last     (tmr_last)
    );

`ifdef MEM_CTRL_RDCACHE_EN
    logic                  cache_valid;
    logic [MEM_WORD_W-1:0] cache_addr;
    logic [MEM_WORD_W-1:0] cache_data;

    assign cache_hit   = cache_valid && (cache_addr == req_addr);
    assign cache_rdata = cache_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
        end else if (rd_done) begin
            cache_valid <= 1'b1;
            cache_addr  <= addr_q;
            cache_data  <= {sram_dq_i, lo_byte};
        end else if (accept && ram_write && cache_hit) begin
            cache_data  <= req_wdata;
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_hi_q <= '0;
            lo_byte    <= '0;
            mem_busy   <= 1'b0;
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (ram_write) begin
                        state      <= WR_LO;
                        mem_busy   <= 1'b1;
                        addr_q     <= req_addr;
                        wdata_hi_q <= req_wdata[15:8];
                        sram_addr  <= {req_addr, 1'b0};
                        sram_dq_o  <= req_wdata[7:0];
                        sram_dq_oe <= 1'b1;
                        sram_ce_n  <= 1'b0;
                        sram_we_n  <= 1'b0;
                    end else if (ram_read && cache_hit) begin
                        state     <= DONE;
                        mem_ready <= 1'b1;
                        mem_rdata <= cache_rdata;
                    end else if (ram_read) begin
                        state     <= RD_LO;
                        mem_busy  <= 1'b1;
                        addr_q    <= req_addr;
                        sram_addr <= {req_addr, 1'b0};
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                    end
                end
                RD_LO: begin
                    if (tmr_last) begin
                        state     <= RD_HI;
                        lo_byte   <= sram_dq_i;
                        sram_addr <= {addr_q, 1'b1};
                    end
                end
                RD_HI: begin
                    if (tmr_last) begin
                        state     <= DONE;
                        mem_busy  <= 1'b0;
                        mem_ready <= 1'b1;
                        mem_rdata <= {sram_dq_i, lo_byte};
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                    end
                end
                WR_LO: begin
                    // we_n rises for the final cycle of each phase to hold address/data.
                    if (tmr_last) begin
                        state     <= WR_HI;
                        sram_addr <= {addr_q, 1'b1};
                        sram_dq_o <= wdata_hi_q;
                        sram_we_n <= 1'b0;
                    end else begin
                        sram_we_n <= (tmr_count == PHASE_CNT_W'(1));
                    end
                end
                WR_HI: begin
                    if (tmr_last) begin
                        state      <= IDLE;
                        mem_busy   <= 1'b0;
                        sram_dq_oe <= 1'b0;
                        sram_ce_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                    end else begin
                        sram_we_n <= (tmr_count == PHASE_CNT_W'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl against a word-level memory model
module tb_mem_ctrl;

    localparam int WS = 1;
    localparam int N  = WS + 1;
    localparam int W  = 2 * N + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_read, ram_write;
    logic [15:0] req_addr, req_wdata;
    logic        mem_busy, mem_ready;
    logic [15:0] mem_rdata;
    logic [16:0] sram_addr;
    logic [7:0]  sram_dq_i, sram_dq_o;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

    logic [7:0]  sram    [0:131071];
    logic [15:0] ref_mem [0:65535];
    bit          m_cvalid;
    logic [15:0] m_caddr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_ctrl #(.WAIT_STATES(WS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ram_read   (ram_read),
        .ram_write  (ram_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_busy   (mem_busy),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .sram_addr  (sram_addr),
        .sram_dq_i  (sram_dq_i),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    always_comb begin
        sram_dq_i = 8'h00;
        if (!sram_ce_n && !sram_oe_n) sram_dq_i = sram[sram_addr];
    end

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_o;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_word(input logic [15:0] a, input logic [15:0] d);
        sram[{a, 1'b0}] = d[7:0];
        sram[{a, 1'b1}] = d[15:8];
        ref_mem[a] = d;
    endtask

    // op: 0 read, 1 write, 2 read+write together
    task automatic run_op(input int op, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_rd, input string tag);
        bit          hit = 1'b0;
        int          busy_cnt = 0, ready_cnt = 0, ready_at = 0, strobe_cnt = 0, we_cnt = 0;
        logic        busy_end = 1'b1;
        logic [15:0] rd = 16'h0;
`ifdef MEM_CTRL_RDCACHE_EN
        hit = (op == 0) && m_cvalid && (m_caddr == addr);
`endif
        @(posedge clk); #1;
        ram_read  = (op != 1);
        ram_write = (op != 0);
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (mem_busy) busy_cnt++;
            if (mem_ready) begin ready_cnt++; ready_at = k; rd = mem_rdata; end
            if (!sram_ce_n) strobe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (k == 2 * N + 1) busy_end = mem_busy;
            if (k < W) begin @(posedge clk); #1; end
        end
        if (op != 0) begin
            check({tag, " wr ready_cnt"}, ready_cnt, 0);
            check({tag, " wr busy_cnt"}, busy_cnt, 2 * N);
            check({tag, " wr busy_end"}, busy_end, 0);
            check({tag, " wr ce_cycles"}, strobe_cnt, 2 * N);
            check({tag, " wr we_cycles"}, we_cnt, 2 * (N - 1));
            check({tag, " wr lo_byte"}, sram[{addr, 1'b0}], wdata[7:0]);
            check({tag, " wr hi_byte"}, sram[{addr, 1'b1}], wdata[15:8]);
            ref_mem[addr] = wdata;
        end else begin
            check({tag, " rd ready_cnt"}, ready_cnt, 1);
            check({tag, " rd ready_at"}, ready_at, hit ? 1 : 2 * N + 1);
            check({tag, " rd busy_cnt"}, busy_cnt, hit ? 0 : 2 * N);
            check({tag, " rd ce_cycles"}, strobe_cnt, hit ? 0 : 2 * N);
            check({tag, " rd data"}, rd, exp_rd);
            check({tag, " rd hold"}, mem_rdata, exp_rd);
            if (!hit) begin m_cvalid = 1'b1; m_caddr = addr; end
        end
    endtask

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k1, k2;
        logic [15:0] r1, r2, a;
        int          op;

        vecs[0] = '{0, 16'h0010, 16'h0000, 16'h1234};
        vecs[1] = '{1, 16'h0011, 16'hBEEF, 16'h0000};
        vecs[2] = '{0, 16'h0011, 16'h0000, 16'hBEEF};
        vecs[3] = '{2, 16'h0012, 16'h5A5A, 16'h0000};
        vecs[4] = '{0, 16'h0012, 16'h0000, 16'h5A5A};
        vecs[5] = '{0, 16'h0010, 16'h0000, 16'h1234};
        vecs[6] = '{0, 16'h0010, 16'h0000, 16'h1234};
        vecs[7] = '{1, 16'h0010, 16'hAAAA, 16'h0000};
        vecs[8] = '{0, 16'h0010, 16'h0000, 16'hAAAA};

        for (int i = 0; i < 131072; i++) sram[i] = 8'h00;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 16'h0000;
        set_word(16'h0010, 16'h1234);
        set_word(16'h0050, 16'h2211);
        set_word(16'h0051, 16'h4433);
        for (int i = 0; i < 8; i++) set_word(16'h0040 + 16'(i), 16'($urandom));
        m_cvalid = 1'b0;
        m_caddr  = 16'h0;

        rst_n = 1'b0; ram_read = 1'b0; ram_write = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", mem_busy, 0);
        check("rst ready", mem_ready, 0);
        check("rst rdata", mem_rdata, 0);
        check("rst addr", sram_addr, 0);
        check("rst dq_o", sram_dq_o, 0);
        check("rst dq_oe", sram_dq_oe, 0);
        check("rst strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, $sformatf("vec%0d", i));

        // Reset during the high-byte read phase.
        @(posedge clk); #1;
        ram_read = 1'b1; req_addr = 16'h0011;
        @(posedge clk); #1;
        ram_read = 1'b0;
        repeat (N) begin @(posedge clk); #1; end
        check("mid rd ce active", sram_ce_n, 0);
        check("mid rd hi addr", sram_addr, 17'h00023);
        rst_n = 1'b0;
        #1;
        check("arst strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check("arst dq_oe", sram_dq_oe, 0);
        check("arst busy", mem_busy, 0);
        check("arst rdata", mem_rdata, 0);
        m_cvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(0, 16'h0011, 16'h0, ref_mem[16'h0011], "post_rst");

        // Back-to-back reads: second request placed in the DONE cycle.
        k1 = 0; k2 = 0; r1 = '0; r2 = '0;
        @(posedge clk); #1;
        ram_read = 1'b1; req_addr = 16'h0050;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            ram_read = 1'b0;
            if (mem_ready && k1 == 0) begin
                k1 = k; r1 = mem_rdata;
                ram_read = 1'b1; req_addr = 16'h0051;
            end else if (mem_ready && k2 == 0) begin
                k2 = k; r2 = mem_rdata;
            end
        end
        check("b2b first ready_at", k1, 2 * N + 1);
        check("b2b gap", k2 - k1, 2 * N + 1);
        check("b2b first data", r1, 16'h2211);
        check("b2b second data", r2, 16'h4433);
        m_cvalid = 1'b1; m_caddr = 16'h0051;

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            a  = 16'h0040 + 16'($urandom_range(0, 7));
            run_op(op, a, 16'($urandom), ref_mem[a], $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
